// File: rtl/rob_pkg.sv
// Shared sizing and entry-type encodings for the reorder buffer slice.
package rob_pkg;

  localparam int ROB_SIZE_DEF  = 8;
  localparam int ROB_WIDTH_DEF = 3;

  typedef enum logic [2:0] {
    ENTRY_REG    = 3'd0,
    ENTRY_STORE  = 3'd1,
    ENTRY_BRANCH = 3'd2
  } entry_type_e;

endpackage

// File: rtl/rob_query.sv
// Combinational operand lookup into the ROB with same-cycle bypass from
// the RS and LSB result broadcasts.
module rob_query
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = ROB_SIZE_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic [ROB_WIDTH-1:0]      id,
  input  logic [ROB_SIZE-1:0]       busy,
  input  logic [ROB_SIZE-1:0]       done,
  input  logic [ROB_SIZE-1:0][31:0] value,
  input  logic                      rs_ready,
  input  logic [ROB_WIDTH-1:0]      rs_rob_id,
  input  logic [31:0]               rs_value,
  input  logic                      lsb_ready,
  input  logic [ROB_WIDTH-1:0]      lsb_rob_id,
  input  logic [31:0]               lsb_value,
  output logic                      qry_ready,
  output logic [31:0]               qry_value
);

  // Stored result first, then RS, then LSB; an idle slot answers nothing.
  always_comb begin
    qry_ready = 1'b0;
    qry_value = '0;
    if (busy[id]) begin
      if (done[id]) begin
        qry_ready = 1'b1;
        qry_value = value[id];
      end else if (rs_ready && rs_rob_id == id) begin
        qry_ready = 1'b1;
        qry_value = rs_value;
      end else if (lsb_ready && lsb_rob_id == id) begin
        qry_ready = 1'b1;
        qry_value = lsb_value;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocation and retirement of in-flight
// instructions, result capture from the RS/LSB buses, mispredict flush.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = ROB_SIZE_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] rob_tail,
  input  logic                 dec_ready,
  input  logic [2:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_pred,
  input  logic [31:0]          dec_alt_pc,
  input  logic [ROB_WIDTH-1:0] qry_j_id,
  input  logic [ROB_WIDTH-1:0] qry_k_id,
  output logic                 qry_j_ready,
  output logic                 qry_k_ready,
  output logic [31:0]          qry_j_value,
  output logic [31:0]          qry_k_value,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 commit_valid,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 store_commit,
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  logic [ROB_SIZE-1:0]       busy;
  logic [ROB_SIZE-1:0]       done;
  logic [ROB_SIZE-1:0][31:0] value;
  logic [ROB_SIZE-1:0]       pred;
  entry_type_e               etype  [ROB_SIZE];
  logic [4:0]                rd     [ROB_SIZE];
  logic [31:0]               alt_pc [ROB_SIZE];
  logic [ROB_WIDTH-1:0]      head;
  logic [ROB_WIDTH-1:0]      tail;
  logic [ROB_WIDTH:0]        count;
  logic                      do_alloc;
  logic                      do_retire;

  assign rob_full  = (count == (ROB_WIDTH+1)'(ROB_SIZE));
  assign rob_tail  = tail;
  assign do_alloc  = dec_ready && !rob_full && !clear;
  assign do_retire = busy[head] && done[head] && !clear;

  // While clear is high the queue only flushes; nothing else moves.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy          <= '0;
      done          <= '0;
      value         <= '0;
      pred          <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        etype[i]  <= ENTRY_REG;
        rd[i]     <= '0;
        alt_pc[i] <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_valid  <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_rob_id <= '0;
      store_commit  <= 1'b0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end else if (rdy_in) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      clear        <= 1'b0;
      if (clear) begin
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_alloc) begin
          busy[tail]   <= 1'b1;
          done[tail]   <= 1'b0;
          etype[tail]  <= entry_type_e'(dec_type);
          rd[tail]     <= dec_rd;
          pred[tail]   <= dec_pred;
          alt_pc[tail] <= dec_alt_pc;
          tail         <= tail + ROB_WIDTH'(1);
        end
        // LSB written first so an RS hit on the same id overrides it.
        for (int i = 0; i < ROB_SIZE; i++) begin
          if (busy[i] && lsb_ready && lsb_rob_id == ROB_WIDTH'(i)) begin
            done[i]  <= 1'b1;
            value[i] <= lsb_value;
          end
          if (busy[i] && rs_ready && rs_rob_id == ROB_WIDTH'(i)) begin
            done[i]  <= 1'b1;
            value[i] <= rs_value;
          end
        end
        if (do_retire) begin
          busy[head]    <= 1'b0;
          head          <= head + ROB_WIDTH'(1);
          commit_rob_id <= head;
          case (etype[head])
            ENTRY_REG: begin
              commit_valid <= 1'b1;
              commit_rd    <= rd[head];
              commit_value <= value[head];
            end
            ENTRY_STORE: store_commit <= 1'b1;
            ENTRY_BRANCH: begin
              if (value[head][0] != pred[head]) begin
                clear    <= 1'b1;
                clear_pc <= alt_pc[head];
              end
            end
            default: ;
          endcase
        end
        case ({do_alloc, do_retire})
          2'b10:   count <= count + (ROB_WIDTH+1)'(1);
          2'b01:   count <= count - (ROB_WIDTH+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  rob_query #(.ROB_SIZE(ROB_SIZE), .ROB_WIDTH(ROB_WIDTH)) u_query_j (
    .id(qry_j_id), .busy(busy), .done(done), .value(value),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .qry_ready(qry_j_ready), .qry_value(qry_j_value)
  );

  rob_query #(.ROB_SIZE(ROB_SIZE), .ROB_WIDTH(ROB_WIDTH)) u_query_k (
    .id(qry_k_id), .busy(busy), .done(done), .value(value),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .qry_ready(qry_k_ready), .qry_value(qry_k_value)
  );

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: allocation, capture, bypass query, in-order
// retire, wrap, mispredict flush, pause and asynchronous reset.
module tb_rob;
  import rob_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_full;
  logic [2:0]  rob_tail;
  logic        dec_ready;
  logic [2:0]  dec_type;
  logic [4:0]  dec_rd;
  logic        dec_pred;
  logic [31:0] dec_alt_pc;
  logic [2:0]  qry_j_id, qry_k_id;
  logic        qry_j_ready, qry_k_ready;
  logic [31:0] qry_j_value, qry_k_value;
  logic        rs_ready, lsb_ready;
  logic [2:0]  rs_rob_id, lsb_rob_id;
  logic [31:0] rs_value, lsb_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_rob_id;
  logic        store_commit;
  logic        clear;
  logic [31:0] clear_pc;

  int tests    = 0;
  int failures = 0;

  rob #(.ROB_SIZE(8), .ROB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .dec_ready(dec_ready), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_pred(dec_pred), .dec_alt_pc(dec_alt_pc),
    .qry_j_id(qry_j_id), .qry_k_id(qry_k_id),
    .qry_j_ready(qry_j_ready), .qry_k_ready(qry_k_ready),
    .qry_j_value(qry_j_value), .qry_k_value(qry_k_value),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .store_commit(store_commit), .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock with the currently driven inputs; one-shot inputs drop afterwards.
  task automatic applyStimulus();
    @(posedge clk_in);
    #1;
    dec_ready = 1'b0;
    rs_ready  = 1'b0;
    lsb_ready = 1'b0;
  endtask

  task automatic allocEntry(input logic [2:0] t, input logic [4:0] r,
                            input logic p, input logic [31:0] a);
    dec_ready  = 1'b1;
    dec_type   = t;
    dec_rd     = r;
    dec_pred   = p;
    dec_alt_pc = a;
  endtask

  task automatic rsSend(input logic [2:0] id, input logic [31:0] v);
    rs_ready  = 1'b1;
    rs_rob_id = id;
    rs_value  = v;
  endtask

  task automatic lsbSend(input logic [2:0] id, input logic [31:0] v);
    lsb_ready  = 1'b1;
    lsb_rob_id = id;
    lsb_value  = v;
  endtask

  task automatic pulseReset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    dec_ready = 1'b0; dec_type = '0; dec_rd = '0; dec_pred = 1'b0; dec_alt_pc = '0;
    qry_j_id = '0; qry_k_id = '0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset_full", rob_full, 0);
    checkOutput("reset_tail", rob_tail, 0);
    checkOutput("reset_commit_valid", commit_valid, 0);
    checkOutput("reset_commit_value", commit_value, 0);
    checkOutput("reset_store_commit", store_commit, 0);
    checkOutput("reset_clear", clear, 0);
    checkOutput("reset_clear_pc", clear_pc, 0);
    checkOutput("reset_qry_ready", qry_j_ready, 0);
    checkOutput("reset_qry_value", qry_j_value, 0);
    rst_in = 1'b0;

    // Basic allocate, capture, retire
    allocEntry(ENTRY_REG, 5'd5, 1'b0, 32'h0); applyStimulus();
    checkOutput("alloc_tail", rob_tail, 1);
    rsSend(3'd0, 32'h1234); applyStimulus();
    checkOutput("no_early_commit", commit_valid, 0);
    applyStimulus();
    checkOutput("commit_valid", commit_valid, 1);
    checkOutput("commit_rd", commit_rd, 5);
    checkOutput("commit_value", commit_value, 32'h1234);
    checkOutput("commit_id", commit_rob_id, 0);
    applyStimulus();
    checkOutput("commit_pulse_width", commit_valid, 0);

    // Fill, overflow attempt, bypass queries, wrap
    pulseReset();
    for (int i = 0; i < 8; i++) begin
      allocEntry(ENTRY_REG, 5'(i + 1), 1'b0, 32'h0); applyStimulus();
    end
    checkOutput("full_flag", rob_full, 1);
    checkOutput("full_tail", rob_tail, 0);
    allocEntry(ENTRY_REG, 5'd31, 1'b0, 32'h0); applyStimulus();
    checkOutput("overflow_tail", rob_tail, 0);
    checkOutput("overflow_full", rob_full, 1);
    qry_j_id = 3'd2; qry_k_id = 3'd3;
    rsSend(3'd2, 32'h55); lsbSend(3'd3, 32'h77);
    #1;
    checkOutput("bypass_rs_ready", qry_j_ready, 1);
    checkOutput("bypass_rs_value", qry_j_value, 32'h55);
    checkOutput("bypass_lsb_ready", qry_k_ready, 1);
    checkOutput("bypass_lsb_value", qry_k_value, 32'h77);
    applyStimulus();
    checkOutput("stored_j_value", qry_j_value, 32'h55);
    checkOutput("stored_k_value", qry_k_value, 32'h77);
    qry_k_id = 3'd4;
    rsSend(3'd4, 32'h44); lsbSend(3'd4, 32'h99);
    #1;
    checkOutput("same_id_bypass_rs_wins", qry_k_value, 32'h44);
    applyStimulus();
    checkOutput("same_id_capture_rs_wins", qry_k_value, 32'h44);
    qry_j_id = 3'd5;
    #1;
    checkOutput("pending_qry_ready", qry_j_ready, 0);
    checkOutput("pending_qry_value", qry_j_value, 0);
    rsSend(3'd0, 32'hA); applyStimulus();
    applyStimulus();
    checkOutput("head_commit_valid", commit_valid, 1);
    checkOutput("head_commit_id", commit_rob_id, 0);
    checkOutput("head_commit_rd", commit_rd, 1);
    checkOutput("head_commit_value", commit_value, 32'hA);
    checkOutput("after_retire_not_full", rob_full, 0);
    allocEntry(ENTRY_REG, 5'd9, 1'b0, 32'h0); applyStimulus();
    checkOutput("wrap_tail", rob_tail, 1);
    checkOutput("wrap_full", rob_full, 1);

    // Out-of-order completion, in-order commit
    pulseReset();
    allocEntry(ENTRY_REG, 5'd1, 1'b0, 32'h0); applyStimulus();
    allocEntry(ENTRY_REG, 5'd2, 1'b0, 32'h0); applyStimulus();
    allocEntry(ENTRY_REG, 5'd3, 1'b0, 32'h0); applyStimulus();
    rsSend(3'd2, 32'h22); applyStimulus();
    lsbSend(3'd1, 32'h11); applyStimulus();
    rsSend(3'd0, 32'h10); applyStimulus();
    checkOutput("ooo_wait_head", commit_valid, 0);
    applyStimulus();
    checkOutput("ooo_c0_id", commit_rob_id, 0);
    checkOutput("ooo_c0_value", commit_value, 32'h10);
    applyStimulus();
    checkOutput("ooo_c1_id", commit_rob_id, 1);
    checkOutput("ooo_c1_value", commit_value, 32'h11);
    applyStimulus();
    checkOutput("ooo_c2_valid", commit_valid, 1);
    checkOutput("ooo_c2_id", commit_rob_id, 2);
    checkOutput("ooo_c2_value", commit_value, 32'h22);
    applyStimulus();
    checkOutput("ooo_drained", commit_valid, 0);

    // Mispredicted branch flushes younger entries
    allocEntry(ENTRY_BRANCH, 5'd0, 1'b1, 32'h100); applyStimulus();
    allocEntry(ENTRY_REG, 5'd7, 1'b0, 32'h0); rsSend(3'd3, 32'h0); applyStimulus();
    allocEntry(ENTRY_STORE, 5'd0, 1'b0, 32'h0); rsSend(3'd4, 32'h4); applyStimulus();
    checkOutput("mispredict_clear", clear, 1);
    checkOutput("mispredict_clear_pc", clear_pc, 32'h100);
    checkOutput("mispredict_no_commit", commit_valid, 0);
    checkOutput("mispredict_tail", rob_tail, 6);
    qry_j_id = 3'd4;
    allocEntry(ENTRY_REG, 5'd8, 1'b0, 32'h0); rsSend(3'd5, 32'h5); applyStimulus();
    checkOutput("flush_clear_drop", clear, 0);
    checkOutput("flush_tail", rob_tail, 0);
    checkOutput("flush_not_full", rob_full, 0);
    checkOutput("flush_commit_blocked", commit_valid, 0);
    checkOutput("flush_qry_ready", qry_j_ready, 0);
    checkOutput("flush_qry_value", qry_j_value, 0);
    applyStimulus();
    checkOutput("flush_young_no_commit", commit_valid, 0);
    checkOutput("flush_young_no_store", store_commit, 0);

    // Correct branch retires silently, store releases
    allocEntry(ENTRY_BRANCH, 5'd0, 1'b0, 32'h200); applyStimulus();
    allocEntry(ENTRY_STORE, 5'd0, 1'b0, 32'h0); rsSend(3'd0, 32'h0); applyStimulus();
    lsbSend(3'd1, 32'hDEAD); applyStimulus();
    checkOutput("good_branch_no_clear", clear, 0);
    checkOutput("good_branch_no_commit", commit_valid, 0);
    checkOutput("good_branch_no_store", store_commit, 0);
    applyStimulus();
    checkOutput("store_commit", store_commit, 1);
    checkOutput("store_commit_id", commit_rob_id, 1);
    applyStimulus();
    checkOutput("store_pulse_width", store_commit, 0);

    // Pause holds everything, then asynchronous reset mid-stream
    allocEntry(ENTRY_REG, 5'd10, 1'b0, 32'h0); applyStimulus();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      allocEntry(ENTRY_REG, 5'd11, 1'b0, 32'h0); rsSend(3'd2, 32'hBEEF); applyStimulus();
    end
    checkOutput("pause_tail", rob_tail, 3);
    rdy_in = 1'b1;
    qry_j_id = 3'd2;
    #1;
    checkOutput("pause_no_capture", qry_j_ready, 0);
    applyStimulus();
    checkOutput("pause_no_commit", commit_valid, 0);
    rsSend(3'd2, 32'h5); applyStimulus();
    applyStimulus();
    checkOutput("resume_commit_valid", commit_valid, 1);
    checkOutput("resume_commit_rd", commit_rd, 10);
    checkOutput("resume_commit_value", commit_value, 32'h5);
    rst_in = 1'b1;
    #1;
    checkOutput("async_reset_commit_valid", commit_valid, 0);
    checkOutput("async_reset_commit_value", commit_value, 0);
    checkOutput("async_reset_tail", rob_tail, 0);
    checkOutput("async_reset_qry_ready", qry_j_ready, 0);
    rst_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
